// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: nibble-serial adder controller that time-shares one external
// 4-bit ripple-carry adder (s[4:0] = a + b, no carry-in). Operands are added
// LSB nibble first. An incoming carry costs one extra FIX cycle, in which the
// adder is reused to add 1 to the partial nibble.
// Optional build macro: RCA_SEQ_CYCLES_EN adds the 8-bit 'cycles' output.
// When enabled, 'cycles' counts the ADD/FIX cycles of the current operation.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// ADD   | adding nibble idx of A and B on the external adder
// FIX   | adding the pending carry into the partial nibble of idx
// DONE  | result presented; waiting for out_ready
module rca_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES:0]     out_sum,
  output logic [3:0]             rca_a,
  output logic [3:0]             rca_b,
  input  logic [4:0]             rca_s,
`ifdef RCA_SEQ_CYCLES_EN
  output logic [7:0]             cycles,
`endif
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [W:0]    out_sum_q, out_sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [3:0]    part_q, part_d;
  logic          c1_q, c1_d;

  logic [IW+1:0] nib_sh;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [3:0]    nib_wr;
  logic          advance;

`ifdef RCA_SEQ_CYCLES_EN
  logic [7:0]    cycles_q, cycles_d;
`endif

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      out_sum_q <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      part_q    <= 4'h0;
      c1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      out_sum_q <= out_sum_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      part_q    <= part_d;
      c1_q      <= c1_d;
    end
  end

  // Next-state, adder operand steering and nibble write-back
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    out_sum_d = out_sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    part_d    = part_q;
    c1_d      = c1_q;
    rca_a     = 4'h0;
    rca_b     = 4'h0;
    nib_wr    = 4'h0;
    advance   = 1'b0;

    nib_sh = {idx_q, 2'b00};
    a_nib  = 4'(a_q >> nib_sh);
    b_nib  = 4'(b_q >> nib_sh);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        rca_a = a_nib;
        rca_b = b_nib;
        if (!carry_q) begin
          nib_wr  = rca_s[3:0];
          carry_d = rca_s[4];
          advance = 1'b1;
        end else begin
          part_d  = rca_s[3:0];
          c1_d    = rca_s[4];
          state_d = FIX;
        end
      end
      FIX: begin
        rca_a   = part_q;
        rca_b   = 4'h1;
        nib_wr  = rca_s[3:0];
        // a+b and the +1 cannot both carry out of the same nibble
        carry_d = c1_q | rca_s[4];
        advance = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      sum_d = (sum_q & ~(W'(4'hF) << nib_sh)) | (W'(nib_wr) << nib_sh);
      if (idx_q == LAST_IDX) begin
        state_d   = DONE;
        // Result register only changes here, so it holds across idle time
        out_sum_d = {carry_d, sum_d};
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = ADD;
      end
    end
  end

`ifdef RCA_SEQ_CYCLES_EN
  // Per-operation cycle counter: cleared on accept, saturating at 255
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == IDLE && in_valid) begin
      cycles_d = 8'h00;
    end else if ((state_q == ADD || state_q == FIX) && cycles_q != 8'hFF) begin
      cycles_d = cycles_q + 8'h01;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycles_q <= 8'h00;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl with NIBBLES=4 and a behavioural 4-bit adder.
module tb_rca_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
  logic [3:0]   rca_a, rca_b;
  logic [4:0]   rca_s;
  logic         busy;
`ifdef RCA_SEQ_CYCLES_EN
  logic [7:0]   cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rca_s = {1'b0, rca_a} + {1'b0, rca_b};

  rca_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .rca_a     (rca_a),
    .rca_b     (rca_b),
    .rca_s     (rca_s),
`ifdef RCA_SEQ_CYCLES_EN
    .cycles    (cycles),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Number of nibbles 1..NIB-1 entered with a carry, i.e. FIX cycles
  function automatic int exp_fix(input logic [W-1:0] a, input logic [W-1:0] b);
    int   f = 0;
    logic c = 1'b0;
    logic [4:0] s;
    for (int i = 0; i < NIB; i++) begin
      if (i > 0 && c) f++;
      s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'h0, c};
      c = s[4];
    end
    return f;
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; records FIX-cycle rca_a
  task automatic wait_done(output int lat, output logic [3:0] fix_a0, output logic [4:0] fix_s0);
    logic seen = 1'b0;
    lat    = 0;
    fix_a0 = 4'h0;
    fix_s0 = 5'h00;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!seen && busy && !out_valid && rca_b == 4'h1 && in_b[7:4] != 4'h1) begin
        seen   = 1'b1;
        fix_a0 = rca_a;
        fix_s0 = rca_s;
      end
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_after"}, out_valid, 0);
    check({tag, "_rdy_after"}, in_ready, 1);
  endtask

  int          lat;
  logic [3:0]  fa;
  logic [4:0]  fs;
  logic [W:0]  held;
  int          rerr0;
  logic [W-1:0] ra, rb;
  int          budget;
  logic        rdy;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_rca_a", rca_a, 0);
    check("rst_rca_b", rca_b, 0);
`ifdef RCA_SEQ_CYCLES_EN
    check("rst_cycles", cycles, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 1: no carries between nibbles
    start_op(16'h1234, 16'h1111);
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 0);
    wait_done(lat, fa, fs);
    check("t1_lat", lat, 4);
    check("t1_sum", out_sum, 17'h02345);
`ifdef RCA_SEQ_CYCLES_EN
    check("t1_cycles", cycles, 4);
`endif
    handshake("t1");

    // 2: carry ripples through every nibble
    start_op(16'hFFFF, 16'h0001);
    wait_done(lat, fa, fs);
    check("t2_lat", lat, 7);
    check("t2_sum", out_sum, 17'h10000);
`ifdef RCA_SEQ_CYCLES_EN
    check("t2_cycles", cycles, 7);
`endif
    handshake("t2");

    // 3: maximum operands, FIX adds 1 to E giving F
    start_op(16'hFFFF, 16'hFFFF);
    wait_done(lat, fa, fs);
    check("t3_lat", lat, 7);
    check("t3_sum", out_sum, 17'h1FFFE);
    check("t3_fix_part", fa, 4'hE);
    check("t3_fix_s", fs, 5'h0F);
    handshake("t3");

    // 4: back-pressure in DONE, in_valid ignored
    start_op(16'h00FF, 16'h0001);
    wait_done(lat, fa, fs);
    check("t4_lat", lat, 6);
    check("t4_sum", out_sum, 17'h00100);
    held = out_sum;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_a     = 16'hAAAA;
      in_b     = 16'h5555;
      @(posedge clk);
      #1;
      check("t4_hold_ov", out_valid, 1);
      check("t4_hold_sum", out_sum, held);
      check("t4_hold_rdy", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_rel_ov", out_valid, 0);
    check("t4_rel_rdy", in_ready, 1);
    check("t4_rel_busy", busy, 0);
    check("t4_keep_sum", out_sum, 17'h00100);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // 5: reset while in FIX
    start_op(16'hFFFF, 16'h0001);
    repeat (2) @(posedge clk);
    #1;
    check("t5_in_fix_a", rca_a, 4'hF);
    check("t5_in_fix_b", rca_b, 4'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rdy", in_ready, 1);
    check("t5_ov", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_rca_a", rca_a, 0);
    check("t5_rca_b", rca_b, 0);
    check("t5_sum", out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(16'h0001, 16'h0001);
    wait_done(lat, fa, fs);
    check("t5_lat", lat, 4);
    check("t5_after_sum", out_sum, 17'h00002);
    handshake("t5");

    // 6: random operands with random sink back-pressure
    rerr0 = errors;
    for (int n = 0; n < 150; n++) begin
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = W'($urandom_range(0, 16'hFFFF));
      start_op(ra, rb);
      wait_done(lat, fa, fs);
      check("r_lat", lat, NIB + exp_fix(ra, rb));
      check("r_sum", out_sum, {1'b0, ra} + {1'b0, rb});
      budget = 0;
      rdy    = 1'b0;
      while (!rdy) begin
        @(negedge clk);
        rdy       = (budget >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        out_ready = rdy;
        @(posedge clk);
        #1;
        budget++;
        if (!rdy) check("r_hold_sum", out_sum, {1'b0, ra} + {1'b0, rb});
      end
      out_ready = 1'b0;
      check("r_idle", in_ready, 1);
    end
    $display("150 tests completed with %0d errors", errors - rerr0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
